udp_ts_rx_pool: RTL and testbench

Multi-channel frame-buffer pointer pool for the UDP TS receive path, and the parametrised successor of the single-channel free-pointer control. It hands out free frame-buffer pointers to up to P_CHANNELS receive DMA engines and accepts released pointers back from the transmit DMA. It enforces a per-channel quota, keeps per-channel occupancy and drop statistics, and exposes status and configuration over Avalon-MM. It runs entirely in the avalon_clk domain; requesters in other domains must synchronise their handshakes before reaching this block.

---
 rtl/udp_ts_rx_pool.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_udp_ts_rx_pool.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_ts_rx_pool.sv
// udp_ts_rx_pool
// Multi-channel free-pointer pool for the UDP TS receive path. A circular
// free list hands frame-buffer pointers to receive DMA channels under a
// per-channel quota and takes released pointers back from the transmit DMA.
// Occupancy, drop counts and sticky error flags are exposed over Avalon-MM.
module udp_ts_rx_pool #(
  parameter int P_POINTERS          = 32,
  parameter int P_POINTER_WIDTH     = 5,
  parameter int P_CHANNELS          = 4,
  parameter int P_CH_WIDTH          = 2,
  parameter int P_AVALON_ADDR_WIDTH = 12,
  parameter logic [P_AVALON_ADDR_WIDTH-1:0] P_BASE_ADD = 12'h320
) (
  input  logic                           avalon_clk,
  input  logic                           avalon_rst,
  input  logic                           fetch_req,
  input  logic [P_CH_WIDTH-1:0]          fetch_channel,
  output logic                           fetch_ack,
  output logic [P_POINTER_WIDTH-1:0]     fetch_pointer,
  output logic                           fetch_fail,
  input  logic                           release_req,
  input  logic [P_POINTER_WIDTH-1:0]     release_pointer,
  output logic                           release_ack,
  input  logic                           avalon_read,
  input  logic                           avalon_write,
  input  logic [P_AVALON_ADDR_WIDTH-1:0] avalon_address,
  input  logic [31:0]                    avalon_writedata,
  output logic [31:0]                    avalon_readdata,
  output logic                           avalon_waitrequest,
  output logic                           initialised,
  output logic                           overflow_any
);

  localparam int PW       = P_POINTER_WIDTH;
  localparam int CNT_W    = P_POINTER_WIDTH + 1;
  localparam int AW       = P_AVALON_ADDR_WIDTH;
  localparam int NUM_REGS = 2 + 2 * P_CHANNELS;

  localparam logic [PW-1:0]    LAST_IDX    = PW'(P_POINTERS - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(P_POINTERS);
  localparam logic [7:0]       QUOTA_RESET = 8'((P_POINTERS > 255) ? 255 : P_POINTERS);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t state;
  state_t state_next;

  // Free list storage and the channel that currently owns each pointer.
  logic [PW-1:0]         mem   [P_POINTERS];
  logic [P_CH_WIDTH-1:0] owner [P_POINTERS];

  logic [PW-1:0]    rd_idx;
  logic [PW-1:0]    wr_idx;
  logic [PW-1:0]    init_idx;
  logic [CNT_W-1:0] count;

  // Per-channel accounting.
  logic [CNT_W-1:0]      occupancy [P_CHANNELS];
  logic [15:0]           drop      [P_CHANNELS];
  logic [7:0]            quota     [P_CHANNELS];
  logic [P_CHANNELS-1:0] overflow;
  logic                  release_error;

  // Per-cycle transaction decisions.
  logic          fetch_do;
  logic          release_do;
  logic          refuse;
  logic          grant;
  logic          double_release;
  logic          push;
  logic          mem_we;
  logic [PW-1:0] mem_wdata;

  // Register decode.
  logic [AW-1:0]         offset;
  logic                  in_range;
  logic                  clear_wr;
  logic [P_CHANNELS-1:0] quota_wr;
  logic [P_CHANNELS-1:0] stats_rd;
  logic [31:0]           status_word;
  logic [31:0]           read_value;

  logic [P_CHANNELS-1:0] occ_inc;
  logic [P_CHANNELS-1:0] occ_dec;
  logic [P_CHANNELS-1:0] drop_event;
  logic [P_CH_WIDTH-1:0] release_owner;
  logic                  unused_writedata;

  assign avalon_waitrequest = 1'b0;
  assign unused_writedata   = ^avalon_writedata;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  // FSM state register.
  always_ff @(posedge avalon_clk or posedge avalon_rst) begin
    if (avalon_rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus fetch/release decisions; fetch uses pre-release count and occupancy.
  always_comb begin
    state_next     = state;
    fetch_do       = 1'b0;
    release_do     = 1'b0;
    refuse         = 1'b0;
    grant          = 1'b0;
    double_release = 1'b0;
    push           = 1'b0;
    mem_we         = 1'b0;
    mem_wdata      = release_pointer;
    case (state)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_wdata = init_idx;
        if (init_idx == LAST_IDX) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        fetch_do       = fetch_req && !fetch_ack;
        release_do     = release_req && !release_ack;
        refuse         = fetch_do && ((count == '0) ||
                         (16'(occupancy[fetch_channel]) >= 16'(quota[fetch_channel])));
        grant          = fetch_do && !refuse;
        double_release = release_do && (count == FULL_COUNT);
        push           = release_do && !double_release;
        mem_we         = push;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Free list write port and owner bookkeeping; INIT reloads the list so no reset is needed.
  always_ff @(posedge avalon_clk) begin
    if (mem_we) begin
      mem[wr_idx] <= mem_wdata;
    end
    if (grant) begin
      owner[mem[rd_idx]] <= fetch_channel;
    end
  end

  // FIFO indices, count, init sequencing and the registered handshake outputs.
  always_ff @(posedge avalon_clk or posedge avalon_rst) begin
    if (avalon_rst) begin
      rd_idx        <= '0;
      wr_idx        <= '0;
      count         <= '0;
      init_idx      <= '0;
      initialised   <= 1'b0;
      fetch_ack     <= 1'b0;
      fetch_fail    <= 1'b0;
      fetch_pointer <= '0;
      release_ack   <= 1'b0;
    end else begin
      fetch_ack   <= fetch_do;
      fetch_fail  <= refuse;
      release_ack <= release_do;
      if (fetch_do) begin
        fetch_pointer <= grant ? mem[rd_idx] : '0;
      end
      if (state == ST_INIT) begin
        init_idx <= init_idx + 1'b1;
        if (init_idx == LAST_IDX) begin
          initialised <= 1'b1;
        end
      end
      if (mem_we) begin
        wr_idx <= next_idx(wr_idx);
      end
      if (grant) begin
        rd_idx <= next_idx(rd_idx);
      end
      case ({mem_we, grant})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign release_owner = owner[release_pointer];

  // Per-channel event strobes derived from this cycle's decisions.
  always_comb begin
    occ_inc    = '0;
    occ_dec    = '0;
    drop_event = '0;
    for (int c = 0; c < P_CHANNELS; c++) begin
      occ_inc[c]    = grant && (fetch_channel == P_CH_WIDTH'(c));
      occ_dec[c]    = push && (release_owner == P_CH_WIDTH'(c)) && (occupancy[c] != '0);
      drop_event[c] = refuse && (fetch_channel == P_CH_WIDTH'(c));
    end
  end

  assign offset   = avalon_address - P_BASE_ADD;
  assign in_range = (avalon_address >= P_BASE_ADD) && (offset < AW'(NUM_REGS));
  assign clear_wr = avalon_write && in_range && (offset == AW'(1));

  // Status word assembly.
  always_comb begin
    status_word    = '0;
    status_word[0] = initialised;
    status_word[1] = release_error;
    for (int c = 0; c < P_CHANNELS; c++) begin
      status_word[16 + c] = overflow[c];
    end
  end

  // Register address decode and read mux; unmapped offsets read zero.
  always_comb begin
    quota_wr   = '0;
    stats_rd   = '0;
    read_value = '0;
    if (in_range && (offset == '0)) begin
      read_value = status_word;
    end
    for (int c = 0; c < P_CHANNELS; c++) begin
      if (in_range && (offset == AW'(2 + c))) begin
        quota_wr[c] = avalon_write;
        read_value  = {24'd0, quota[c]};
      end
      if (in_range && (offset == AW'(2 + P_CHANNELS + c))) begin
        stats_rd[c] = avalon_read;
        read_value  = {drop[c], 16'(occupancy[c])};
      end
    end
  end

  // Per-channel occupancy, drop counters, quotas and sticky overflow flags.
  always_ff @(posedge avalon_clk or posedge avalon_rst) begin
    if (avalon_rst) begin
      for (int c = 0; c < P_CHANNELS; c++) begin
        occupancy[c] <= '0;
        drop[c]      <= '0;
        quota[c]     <= QUOTA_RESET;
      end
      overflow <= '0;
    end else begin
      for (int c = 0; c < P_CHANNELS; c++) begin
        case ({occ_inc[c], occ_dec[c]})
          2'b10:   occupancy[c] <= occupancy[c] + 1'b1;
          2'b01:   occupancy[c] <= occupancy[c] - 1'b1;
          default: occupancy[c] <= occupancy[c];
        endcase
        if (stats_rd[c]) begin
          drop[c] <= drop_event[c] ? 16'd1 : 16'd0;
        end else if (drop_event[c] && (drop[c] != 16'hFFFF)) begin
          drop[c] <= drop[c] + 1'b1;
        end
        if (drop_event[c]) begin
          overflow[c] <= 1'b1;
        end else if (clear_wr && avalon_writedata[16 + c]) begin
          overflow[c] <= 1'b0;
        end
        if (quota_wr[c]) begin
          quota[c] <= avalon_writedata[7:0];
        end
      end
    end
  end

  // Release error flag, overflow summary and registered read data.
  always_ff @(posedge avalon_clk or posedge avalon_rst) begin
    if (avalon_rst) begin
      release_error   <= 1'b0;
      overflow_any    <= 1'b0;
      avalon_readdata <= '0;
    end else begin
      if (double_release) begin
        release_error <= 1'b1;
      end else if (clear_wr && avalon_writedata[1]) begin
        release_error <= 1'b0;
      end
      overflow_any <= |overflow;
      if (avalon_read) begin
        avalon_readdata <= read_value;
      end
    end
  end

endmodule

// File: tb/tb_udp_ts_rx_pool.sv
// tb_udp_ts_rx_pool
// Directed and randomized checks of the pointer pool against a queue-based
// model of the free list, per-channel quotas, drop counters and flags.
module tb_udp_ts_rx_pool;

  localparam int P  = 32;
  localparam int PW = 5;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int AW = 12;
  localparam logic [AW-1:0] BASE = 12'h320;

  logic          avalon_clk;
  logic          avalon_rst;
  logic          fetch_req;
  logic [CW-1:0] fetch_channel;
  logic          fetch_ack;
  logic [PW-1:0] fetch_pointer;
  logic          fetch_fail;
  logic          release_req;
  logic [PW-1:0] release_pointer;
  logic          release_ack;
  logic          avalon_read;
  logic          avalon_write;
  logic [AW-1:0] avalon_address;
  logic [31:0]   avalon_writedata;
  logic [31:0]   avalon_readdata;
  logic          avalon_waitrequest;
  logic          initialised;
  logic          overflow_any;

  udp_ts_rx_pool #(
    .P_POINTERS(P), .P_POINTER_WIDTH(PW), .P_CHANNELS(NC), .P_CH_WIDTH(CW),
    .P_AVALON_ADDR_WIDTH(AW), .P_BASE_ADD(BASE)
  ) dut (
    .avalon_clk(avalon_clk), .avalon_rst(avalon_rst),
    .fetch_req(fetch_req), .fetch_channel(fetch_channel), .fetch_ack(fetch_ack),
    .fetch_pointer(fetch_pointer), .fetch_fail(fetch_fail),
    .release_req(release_req), .release_pointer(release_pointer), .release_ack(release_ack),
    .avalon_read(avalon_read), .avalon_write(avalon_write), .avalon_address(avalon_address),
    .avalon_writedata(avalon_writedata), .avalon_readdata(avalon_readdata),
    .avalon_waitrequest(avalon_waitrequest), .initialised(initialised),
    .overflow_any(overflow_any)
  );

  initial avalon_clk = 1'b0;
  always #5 avalon_clk = ~avalon_clk;

  // Reference model state.
  int free_q[$];
  int held[$];
  int owner_m [P];
  int occ     [NC];
  int drop_m  [NC];
  int quota_m [NC];
  bit ovf_m   [NC];
  bit rel_err_m;
  bit init_m;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    free_q.delete();
    held.delete();
    for (int i = 0; i < P; i++) begin
      free_q.push_back(i);
      owner_m[i] = 0;
    end
    for (int c = 0; c < NC; c++) begin
      occ[c] = 0; drop_m[c] = 0; quota_m[c] = P; ovf_m[c] = 1'b0;
    end
    rel_err_m = 1'b0;
    init_m    = 1'b0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = init_m;
    s[1] = rel_err_m;
    for (int c = 0; c < NC; c++) s[16 + c] = ovf_m[c];
    return s;
  endfunction

  function automatic logic [31:0] m_stats(input int c);
    logic [31:0] v;
    v = {drop_m[c][15:0], occ[c][15:0]};
    drop_m[c] = 0;
    return v;
  endfunction

  function automatic bit m_any_ovf();
    bit a;
    a = 1'b0;
    for (int c = 0; c < NC; c++) a |= ovf_m[c];
    return a;
  endfunction

  // One pool cycle in the model: fetch judged on pre-release count, then release.
  task automatic model_step(input bit f, input int ch, input bit r, input int p,
                            output bit exp_fail, output int exp_ptr);
    int pre;
    pre      = free_q.size();
    exp_fail = 1'b0;
    exp_ptr  = 0;
    if (f) begin
      if (pre == 0 || occ[ch] >= quota_m[ch]) begin
        exp_fail  = 1'b1;
        ovf_m[ch] = 1'b1;
        if (drop_m[ch] < 65535) drop_m[ch]++;
      end else begin
        exp_ptr = free_q.pop_front();
        owner_m[exp_ptr] = ch;
        occ[ch]++;
        held.push_back(exp_ptr);
      end
    end
    if (r) begin
      if (pre == P) begin
        rel_err_m = 1'b1;
      end else begin
        free_q.push_back(p);
        if (occ[owner_m[p]] > 0) occ[owner_m[p]]--;
        for (int i = 0; i < held.size(); i++) begin
          if (held[i] == p) begin
            held.delete(i);
            break;
          end
        end
      end
    end
  endtask

  // Drive one fetch and/or release request and check the acknowledge cycle.
  task automatic apply_stimulus(input bit f, input int ch, input bit r, input int p, input string tag);
    bit ef;
    int ep;
    @(negedge avalon_clk);
    check_output({tag, ".overflow_any"}, 32'(overflow_any), 32'(m_any_ovf()));
    fetch_req       = f;
    fetch_channel   = CW'(ch);
    release_req     = r;
    release_pointer = PW'(p);
    model_step(f, ch, r, p, ef, ep);
    @(negedge avalon_clk);
    check_output({tag, ".fetch_ack"}, 32'(fetch_ack), 32'(f));
    if (f) begin
      check_output({tag, ".fetch_fail"}, 32'(fetch_fail), 32'(ef));
      if (!ef) check_output({tag, ".fetch_pointer"}, 32'(fetch_pointer), 32'(ep));
    end
    check_output({tag, ".release_ack"}, 32'(release_ack), 32'(r));
    fetch_req   = 1'b0;
    release_req = 1'b0;
  endtask

  task automatic reg_read(input int off, input logic [31:0] exp, input string tag);
    @(negedge avalon_clk);
    avalon_read    = 1'b1;
    avalon_address = BASE + AW'(off);
    @(negedge avalon_clk);
    avalon_read = 1'b0;
    check_output(tag, avalon_readdata, exp);
  endtask

  task automatic reg_write(input int off, input logic [31:0] data);
    @(negedge avalon_clk);
    avalon_write     = 1'b1;
    avalon_address   = BASE + AW'(off);
    avalon_writedata = data;
    @(negedge avalon_clk);
    avalon_write = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int k;
    for (k = 1; k <= 100; k++) begin
      @(negedge avalon_clk);
      if (initialised) break;
    end
    check_output(tag, 32'(k), 32'(P));
    init_m = 1'b1;
  endtask

  initial begin
    bit ef;
    int ep;
    logic [31:0] exp_rd;

    avalon_rst = 1'b1;
    fetch_req = 1'b0; fetch_channel = '0; release_req = 1'b0; release_pointer = '0;
    avalon_read = 1'b0; avalon_write = 1'b0; avalon_address = '0; avalon_writedata = '0;
    model_reset();

    // Reset values.
    repeat (3) @(negedge avalon_clk);
    check_output("rst.fetch_ack", 32'(fetch_ack), 32'd0);
    check_output("rst.release_ack", 32'(release_ack), 32'd0);
    check_output("rst.fetch_fail", 32'(fetch_fail), 32'd0);
    check_output("rst.fetch_pointer", 32'(fetch_pointer), 32'd0);
    check_output("rst.initialised", 32'(initialised), 32'd0);
    check_output("rst.overflow_any", 32'(overflow_any), 32'd0);
    check_output("rst.readdata", avalon_readdata, 32'd0);
    check_output("rst.waitrequest", 32'(avalon_waitrequest), 32'd0);
    avalon_rst = 1'b0;
    wait_init("init_cycles");

    reg_read(0, m_status(), "status_after_init");
    reg_read(2, 32'(quota_m[0]), "quota0_reset");
    reg_read(2 + 2 * NC, 32'd0, "unmapped_above");
    reg_read(-1, 32'd0, "unmapped_below");
    reg_write(2 + 2 * NC, 32'hFFFF_FFFF);
    reg_read(0, m_status(), "status_after_unmapped_write");

    // Drain the whole pool on channel 0, then overflow it.
    $display("[TB] fill channel 0");
    for (int i = 0; i < P; i++) apply_stimulus(1, 0, 0, 0, "fill_ch0");
    apply_stimulus(1, 0, 0, 0, "fetch33");
    reg_read(0, m_status(), "status_overflow0");
    reg_read(2 + NC, m_stats(0), "stats0_first");
    reg_read(2 + NC, m_stats(0), "stats0_reread");

    // Return pointer 5 and fetch it straight back.
    apply_stimulus(0, 0, 1, 5, "release5");
    reg_read(2 + NC, m_stats(0), "stats0_after_release");
    apply_stimulus(1, 0, 0, 0, "refetch5");

    // Empty pool: concurrent fetch refused, release accepted, count ends at 1.
    apply_stimulus(1, 0, 1, 7, "empty_simul");
    apply_stimulus(1, 1, 0, 0, "after_simul_grant");
    apply_stimulus(1, 1, 0, 0, "after_simul_empty");
    reg_write(1, 32'h000F_0000);
    for (int c = 0; c < NC; c++) ovf_m[c] = 1'b0;
    reg_read(0, m_status(), "status_after_w1c");

    // Reset in the middle of a fetch burst.
    $display("[TB] mid-operation reset");
    for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 1, held[0], "prep_release");
    for (int i = 0; i < 3; i++) apply_stimulus(1, 2, 0, 0, "burst_fetch");
    @(negedge avalon_clk);
    fetch_req = 1'b1;
    fetch_channel = 2'd2;
    @(posedge avalon_clk);
    #1;
    check_output("mid.ack_before_reset", 32'(fetch_ack), 32'd1);
    avalon_rst = 1'b1;
    #1;
    check_output("mid.fetch_ack", 32'(fetch_ack), 32'd0);
    check_output("mid.release_ack", 32'(release_ack), 32'd0);
    check_output("mid.initialised", 32'(initialised), 32'd0);
    check_output("mid.fetch_pointer", 32'(fetch_pointer), 32'd0);
    fetch_req = 1'b0;
    model_reset();
    @(negedge avalon_clk);
    avalon_rst = 1'b0;
    wait_init("reinit_cycles");

    // Double release on a full pool.
    apply_stimulus(0, 0, 1, 3, "double_release");
    reg_read(0, m_status(), "status_release_error");
    reg_write(1, 32'h0000_0002);
    rel_err_m = 1'b0;
    reg_read(0, m_status(), "status_release_error_cleared");
    apply_stimulus(1, 0, 0, 0, "first_fetch_after_reset");

    // Quota of 2 on channel 1.
    reg_write(3, 32'd2);
    quota_m[1] = 2;
    reg_read(3, 32'd2, "quota1_readback");
    for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 0, 0, "quota1_fetch");
    reg_read(2 + NC + 1, m_stats(1), "stats1_first");
    reg_read(2 + NC + 1, m_stats(1), "stats1_reread");

    // Drop landing in the same cycle as the clearing read restarts at 1.
    @(negedge avalon_clk);
    fetch_req = 1'b1; fetch_channel = 2'd1;
    avalon_read = 1'b1; avalon_address = BASE + AW'(2 + NC + 1);
    exp_rd = m_stats(1);
    model_step(1, 1, 0, 0, ef, ep);
    @(negedge avalon_clk);
    fetch_req = 1'b0; avalon_read = 1'b0;
    check_output("drop_read_race.readdata", avalon_readdata, exp_rd);
    check_output("drop_read_race.fail", 32'(fetch_fail), 32'(ef));
    reg_read(2 + NC + 1, m_stats(1), "drop_read_race.restart");

    // Set and clear of overflow[1] in the same cycle: set wins.
    @(negedge avalon_clk);
    fetch_req = 1'b1; fetch_channel = 2'd1;
    avalon_write = 1'b1; avalon_address = BASE + AW'(1); avalon_writedata = 32'h0002_0000;
    model_step(1, 1, 0, 0, ef, ep);
    @(negedge avalon_clk);
    fetch_req = 1'b0; avalon_write = 1'b0;
    check_output("set_wins.fail", 32'(fetch_fail), 32'(ef));
    reg_read(0, m_status(), "set_wins.status");

    // Randomized traffic against the model.
    $display("[TB] random traffic");
    for (int it = 0; it < 300; it++) begin
      int sel, ch, p;
      logic [31:0] d;
      sel = $urandom_range(0, 9);
      ch  = $urandom_range(0, NC - 1);
      if (held.size() > 0) p = held[$urandom_range(0, held.size() - 1)];
      else p = $urandom_range(0, P - 1);
      case (sel)
        0, 1, 2, 3: apply_stimulus(1, ch, 0, 0, "rnd_fetch");
        4, 5:       apply_stimulus(0, 0, 1, p, "rnd_release");
        6:          apply_stimulus(1, ch, 1, p, "rnd_both");
        7: begin
          d = 32'($urandom_range(0, 12));
          reg_write(2 + ch, d);
          quota_m[ch] = int'(d);
        end
        8: reg_read(2 + NC + ch, m_stats(ch), "rnd_stats");
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            reg_read(0, m_status(), "rnd_status");
          end else begin
            d = $urandom & 32'h000F_0002;
            reg_write(1, d);
            if (d[1]) rel_err_m = 1'b0;
            for (int c = 0; c < NC; c++) if (d[16 + c]) ovf_m[c] = 1'b0;
          end
        end
      endcase
    end
    reg_read(0, m_status(), "final_status");
    for (int c = 0; c < NC; c++) reg_read(2 + NC + c, m_stats(c), "final_stats");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
